// File: rtl/fifo_gray_ptr_ctrl.sv
// fifo_gray_ptr_ctrl: pointer, Gray-code and status-flag controller for a single-clock FIFO
module fifo_gray_ptr_ctrl #(
  parameter int AW = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic        soft_reset_i,
  input  logic        write_enb_i,
  input  logic        read_enb_i,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [AW-1:0] waddr_o,
  output logic [AW-1:0] raddr_o,
  output logic [AW:0] wptr_gray_o,
  output logic [AW:0] rptr_gray_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        almost_full_o,
  output logic        almost_empty_o,
  output logic [AW:0] count_o,
  output logic        overflow_o,
  output logic        underflow_o
);
  localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE = (AW+1)'(AE_LEVEL);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d, wgray_q, rgray_q;
  logic full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q, clr, wr_ok, rd_ok;
  // Reset and flush both suppress the RAM strobes so nothing is written during a clear.
  always_comb begin
    clr = ~resetn_i | soft_reset_i;
    wr_ok = write_enb_i & ~full_q & ~clr;
    rd_ok = read_enb_i & ~empty_q & ~clr;
    wptr_d = wptr_q + {{AW{1'b0}}, wr_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_ok};
    count_d = wptr_d - rptr_d;
  end
  always_ff @(posedge clock_i) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wgray_q <= '0;
      rgray_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wgray_q <= wptr_d ^ (wptr_d >> 1);
      rgray_q <= rptr_d ^ (rptr_d >> 1);
      count_q <= count_d;
      full_q <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_q <= wptr_d == rptr_d;
      afull_q <= count_d >= AF;
      aempty_q <= count_d <= AE;
      ovf_q <= ovf_q | (write_enb_i & full_q);
      unf_q <= unf_q | (read_enb_i & empty_q);
    end
  end
  assign mem_we_o = wr_ok;
  assign mem_re_o = rd_ok;
  assign waddr_o = wptr_q[AW-1:0];
  assign raddr_o = rptr_q[AW-1:0];
  assign wptr_gray_o = wgray_q;
  assign rptr_gray_o = rgray_q;
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign almost_full_o = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o = count_q;
  assign overflow_o = ovf_q;
  assign underflow_o = unf_q;
endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// tb_fifo_gray_ptr_ctrl: occupancy-level reference model with per-cycle comparison plus
// directed fill/drain/wrap/simultaneous/flush scenarios and a randomized phase.
module tb_fifo_gray_ptr_ctrl;
  logic clock_i = 1'b0, resetn_i = 1'b0, soft_reset_i = 1'b0, write_enb_i = 1'b0, read_enb_i = 1'b0;
  logic mem_we_o, mem_re_o, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [3:0] waddr_o, raddr_o;
  logic [4:0] wptr_gray_o, rptr_gray_o, count_o;
  int n_chk = 0, n_fail = 0;
  int m_wp = 0, m_rp = 0, m_cnt = 0;
  bit m_ovf = 0, m_unf = 0, m_clr = 1, chk_en = 0;
  logic [4:0] prev_wg, prev_rg;

  fifo_gray_ptr_ctrl #(.AW(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clock_i(clock_i), .resetn_i(resetn_i), .soft_reset_i(soft_reset_i),
    .write_enb_i(write_enb_i), .read_enb_i(read_enb_i),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .waddr_o(waddr_o), .raddr_o(raddr_o),
    .wptr_gray_o(wptr_gray_o), .rptr_gray_o(rptr_gray_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o));

  always #5 clock_i = ~clock_i;

  function automatic logic [4:0] gray(int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is tracked as a plain integer, pointers as counters mod 32.
  always @(posedge clock_i) begin
    bit wok, rok;
    if (!resetn_i || soft_reset_i) begin
      m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_clr = 1;
    end else begin
      wok = write_enb_i && m_cnt < 16;
      rok = read_enb_i && m_cnt > 0;
      if (write_enb_i && m_cnt == 16) m_ovf = 1;
      if (read_enb_i && m_cnt == 0) m_unf = 1;
      m_wp = (m_wp + int'(wok)) % 32;
      m_rp = (m_rp + int'(rok)) % 32;
      m_cnt = m_cnt + int'(wok) - int'(rok);
      m_clr = 0;
    end
  end

  always @(negedge clock_i) begin
    bit clr;
    if (chk_en) begin
      clr = !resetn_i || soft_reset_i;
      check("mem_we", mem_we_o, write_enb_i && m_cnt < 16 && !clr);
      check("mem_re", mem_re_o, read_enb_i && m_cnt > 0 && !clr);
      check("waddr", waddr_o, m_wp % 16);
      check("raddr", raddr_o, m_rp % 16);
      check("wptr_gray", wptr_gray_o, gray(m_wp));
      check("rptr_gray", rptr_gray_o, gray(m_rp));
      check("count", count_o, m_cnt);
      check("full", full_o, m_cnt == 16);
      check("empty", empty_o, m_cnt == 0);
      check("almost_full", almost_full_o, m_cnt >= 14);
      check("almost_empty", almost_empty_o, m_cnt <= 2);
      check("overflow", overflow_o, m_ovf);
      check("underflow", underflow_o, m_unf);
      if (!m_clr && wptr_gray_o != prev_wg) check("wgray_step", $countones(wptr_gray_o ^ prev_wg), 1);
      if (!m_clr && rptr_gray_o != prev_rg) check("rgray_step", $countones(rptr_gray_o ^ prev_rg), 1);
      prev_wg = wptr_gray_o;
      prev_rg = rptr_gray_o;
    end
  end

  task automatic cyc(bit we, bit re);
    write_enb_i = we;
    read_enb_i = re;
    @(posedge clock_i);
    #1;
  endtask

  task automatic flush();
    soft_reset_i = 1;
    cyc(0, 0);
    soft_reset_i = 0;
  endtask

  initial begin
    write_enb_i = 1;
    @(posedge clock_i);
    #1 chk_en = 1;
    #1 check("reset_mem_we", mem_we_o, 0);
    check("reset_count", count_o, 0);
    check("reset_empty", empty_o, 1);
    check("reset_wgray", wptr_gray_o, 0);
    resetn_i = 1;
    cyc(0, 0);
    // fill
    for (int i = 0; i < 13; i++) cyc(1, 0);
    check("af_before_14", almost_full_o, 0);
    cyc(1, 0);
    check("af_after_14", almost_full_o, 1);
    cyc(1, 0);
    cyc(1, 0);
    check("fill_full", full_o, 1);
    check("fill_count", count_o, 16);
    check("fill_wgray", wptr_gray_o, 5'b11000);
    write_enb_i = 1;
    #1 check("ovf_mem_we", mem_we_o, 0);
    cyc(1, 0);
    check("ovf_set", overflow_o, 1);
    // drain
    for (int i = 0; i < 16; i++) cyc(0, 1);
    check("drain_empty", empty_o, 1);
    check("drain_count", count_o, 0);
    check("drain_rgray", rptr_gray_o, 5'b11000);
    read_enb_i = 1;
    #1 check("unf_mem_re", mem_re_o, 0);
    cyc(0, 1);
    check("unf_set", underflow_o, 1);
    check("ovf_sticky", overflow_o, 1);
    // wrap with low occupancy
    for (int i = 0; i < 40; i++) begin
      cyc(1, i % 3 == 2);
      cyc(0, 1);
    end
    // simultaneous at count 5
    flush();
    for (int i = 0; i < 5; i++) cyc(1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1);
    check("simul_count", count_o, 5);
    check("simul_waddr", waddr_o, 9);
    check("simul_raddr", raddr_o, 4);
    for (int i = 0; i < 11; i++) cyc(1, 0);
    check("simul_full", full_o, 1);
    cyc(1, 1);
    check("full_both_count", count_o, 15);
    check("full_both_ovf", overflow_o, 1);
    // soft reset mid-operation
    flush();
    for (int i = 0; i < 7; i++) cyc(1, 0);
    check("pre_sr_count", count_o, 7);
    soft_reset_i = 1;
    write_enb_i = 1;
    #1 check("sr_mem_we", mem_we_o, 0);
    cyc(1, 0);
    soft_reset_i = 0;
    check("sr_count", count_o, 0);
    check("sr_empty", empty_o, 1);
    check("sr_wgray", wptr_gray_o, 0);
    check("sr_ovf", overflow_o, 0);
    cyc(0, 0);
    // randomized phase with biased occupancy drift and rare clears
    for (int i = 0; i < 2000; i++) begin
      int bias;
      bias = (i / 200) % 2 ? 75 : 25;
      soft_reset_i = $urandom_range(0, 199) == 0;
      resetn_i = $urandom_range(0, 299) != 0;
      cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias);
    end
    resetn_i = 1;
    soft_reset_i = 0;
    cyc(0, 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
